// File: rtl/adder_multiword_seq_pkg.sv
// adder_multiword_seq_pkg: state encoding and nibble width shared by the multiword adder sequencer
package adder_multiword_seq_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_parallel_4_bit.sv
// adder_parallel_4_bit: 4-bit ripple adder exposing the carry out of every bit position
module adder_parallel_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       incarry,
  output logic [3:0] sum,
  output logic [3:0] outcarry
);
  logic c;
  always_comb begin
    sum = '0;
    outcarry = '0;
    c = incarry;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      outcarry[i] = c;
    end
  end
endmodule

// File: rtl/adder_multiword_seq.sv
// adder_multiword_seq: WIDTH-bit add/subtract time-multiplexed over one 4-bit adder, LSB nibble first
module adder_multiword_seq
  import adder_multiword_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             incarry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             outcarry,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic c_q;
  logic [IW-1:0] idx;
  logic [NIB_W-1:0] nib_sum, nib_c;
  logic last, accept;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = idx == IW'(NIBBLES - 1);
  // DONE accepts a start exactly like IDLE, giving back-to-back operations
  assign accept = start && !busy;
  adder_parallel_4_bit u_add (
    .a        (a_q[idx*NIB_W +: NIB_W]),
    .b        (b_q[idx*NIB_W +: NIB_W]),
    .incarry  (c_q),
    .sum      (nib_sum),
    .outcarry (nib_c)
  );
  always_comb begin
    state_n = state;
    state_n = busy ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      outcarry <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= num1;
        b_q <= sub ? ~num2 : num2;
        c_q <= sub | incarry;
        idx <= '0;
      end else if (busy) begin
        sum[idx*NIB_W +: NIB_W] <= nib_sum;
        c_q <= nib_c[3];
        idx <= idx + 1'b1;
        if (last) begin
          outcarry <= nib_c[3];
          overflow <= nib_c[2] ^ nib_c[3];
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_multiword_seq.sv
// tb_adder_multiword_seq: directed vectors with hand-computed results for 16-bit and 4-bit builds
module tb_adder_multiword_seq;
  logic clk = 1'b0;
  logic reset, start, sub, incarry, busy, done, outcarry, overflow;
  logic [15:0] num1, num2, sum;
  logic start4, incarry4, busy4, done4, outcarry4, overflow4;
  logic [3:0] num1_4, num2_4, sum4;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_multiword_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .num1(num1), .num2(num2),
    .incarry(incarry), .busy(busy), .done(done), .sum(sum), .outcarry(outcarry),
    .overflow(overflow)
  );

  adder_multiword_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(1'b0), .num1(num1_4), .num2(num2_4),
    .incarry(incarry4), .busy(busy4), .done(done4), .sum(sum4), .outcarry(outcarry4),
    .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic s, input logic [15:0] a, input logic [15:0] b, input logic ci);
    sub = s; num1 = a; num2 = b; incarry = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
  endtask

  task automatic res(input string tag, input logic [15:0] s, input logic c, input logic v);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_carry"}, outcarry, c);
    chk({tag, "_ovf"}, overflow, v);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; incarry = 1'b0; num1 = '0; num2 = '0;
    start4 = 1'b0; incarry4 = 1'b0; num1_4 = '0; num2_4 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    res("rst", 16'h0000, 0, 0);

    op(0, 16'h1234, 16'h0FFF, 0);
    res("add1", 16'h2233, 0, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("sum_hold", sum, 16'h2233);

    op(0, 16'hFFFF, 16'h0001, 0);
    res("add_wrap", 16'h0000, 1, 0);
    @(negedge clk);
    op(0, 16'h7FFF, 16'h0000, 1);
    res("add_ovf", 16'h8000, 0, 1);
    @(negedge clk);
    op(1, 16'h0005, 16'h0007, 1);
    res("sub_borrow", 16'hFFFE, 0, 0);
    @(negedge clk);
    op(1, 16'h8000, 16'h0001, 0);
    res("sub_ovf", 16'h7FFF, 1, 1);
    @(negedge clk);

    // start pulsed mid-RUN must be ignored
    sub = 0; num1 = 16'h0001; num2 = 16'h0001; incarry = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    num1 = 16'hAAAA; num2 = 16'h5555; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("ign_busy", busy, 1);
    @(negedge clk);
    chk("ign_done", done, 1);
    res("ign", 16'h0002, 0, 0);
    op(0, 16'h00F0, 16'h0010, 0);
    res("b2b", 16'h0100, 0, 0);
    @(negedge clk);

    op(1, 16'h8000, 16'h0001, 0);
    @(negedge clk);
    sub = 0; num1 = 16'h1111; num2 = 16'h2222; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    res("abort", 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    op(0, 16'h0003, 16'h0004, 0);
    res("after_abort", 16'h0007, 0, 0);

    num1_4 = 4'hF; num2_4 = 4'h1; incarry4 = 0; start4 = 1;
    @(negedge clk);
    start4 = 0;
    chk("w4_busy", busy4, 1);
    chk("w4_done_early", done4, 0);
    @(negedge clk);
    chk("w4_done", done4, 1);
    chk("w4_sum", sum4, 4'h0);
    chk("w4_carry", outcarry4, 1);
    chk("w4_ovf", overflow4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
